// File: rtl/pong_pkg.sv
// Shared encodings for the pong game-flow controller.
package pong_pkg;
  typedef enum logic [2:0] {
    SERVE = 3'd0,
    PLAY  = 3'd1,
    POINT = 3'd2,
    OVER  = 3'd3
  } state_t;

  localparam logic [1:0] SIDE_P1   = 2'b10;
  localparam logic [1:0] SIDE_P2   = 2'b01;
  localparam logic [1:0] SIDE_NONE = 2'b00;

  localparam logic [9:0] DEF_LEFT_LIMIT  = 10'd8;
  localparam logic [9:0] DEF_RIGHT_LIMIT = 10'd632;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
endpackage

// File: rtl/edge_rise.sv
// One-bit rising-edge detector against a registered copy of the input.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;

  assign rise = d & ~d_q;
endmodule

// File: rtl/pong_referee.sv
// Pong game-flow FSM: serve, rally, point pause and game-over handling.
module pong_referee
  import pong_pkg::*;
#(
  parameter int         WIN_SCORE    = 9,
  parameter logic [9:0] LEFT_LIMIT   = DEF_LEFT_LIMIT,
  parameter logic [9:0] RIGHT_LIMIT  = DEF_RIGHT_LIMIT,
  parameter logic [7:0] POINT_FRAMES = 8'd60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [9:0] ball_x,
  input  logic       p1_srv,
  input  logic       p2_srv,
  output logic [1:0] side,
  output logic       launch,
  output logic       launch_dir,
  output logic       ball_rst,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);
  state_t     st;
  logic [7:0] pt_cnt;
  logic [1:0] srv, srv_rise;
  logic       p1_rise, p2_rise;
  logic       hit_l, hit_r;
  logic [3:0] new_score;

  assign srv = {p1_srv, p2_srv};
  for (genvar i = 0; i < 2; i++) begin : g_srv
    edge_rise u_edge (.clk(clk), .rst_n(rst_n), .d(srv[i]), .rise(srv_rise[i]));
  end
  assign p1_rise = srv_rise[1];
  assign p2_rise = srv_rise[0];

  // Left boundary wins if both somehow hold.
  assign hit_l     = frame_tick && (ball_x <= LEFT_LIMIT);
  assign hit_r     = frame_tick && !hit_l && (ball_x >= RIGHT_LIMIT);
  assign new_score = hit_l ? sat_inc(score_p2) : sat_inc(score_p1);
  assign state     = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= SERVE;
      side       <= SIDE_P2;
      launch     <= 1'b0;
      launch_dir <= 1'b0;
      ball_rst   <= 1'b0;
      score_p1   <= 4'd0;
      score_p2   <= 4'd0;
      game_over  <= 1'b0;
      winner     <= 1'b0;
      pt_cnt     <= 8'd0;
    end else begin
      launch   <= 1'b0;
      ball_rst <= 1'b0;
      case (st)
        SERVE: begin
          if (side[1] && p1_rise) begin
            launch     <= 1'b1;
            launch_dir <= 1'b0;
            side       <= SIDE_NONE;
            st         <= PLAY;
          end else if (side[0] && p2_rise) begin
            launch     <= 1'b1;
            launch_dir <= 1'b1;
            side       <= SIDE_NONE;
            st         <= PLAY;
          end
        end
        PLAY: begin
          if (hit_l || hit_r) begin
            ball_rst <= 1'b1;
            if (hit_l) score_p2 <= new_score;
            else       score_p1 <= new_score;
            if (new_score == 4'(WIN_SCORE)) begin
              st        <= OVER;
              game_over <= 1'b1;
              winner    <= hit_l;
              side      <= SIDE_NONE;
            end else begin
              // Conceding player serves next.
              side <= hit_l ? SIDE_P1 : SIDE_P2;
              if (POINT_FRAMES == 8'd0) begin
                st <= SERVE;
              end else begin
                st     <= POINT;
                pt_cnt <= POINT_FRAMES;
              end
            end
          end
        end
        POINT: begin
          if (frame_tick) begin
            if (pt_cnt == 8'd0) st <= SERVE;
            else                pt_cnt <= pt_cnt - 8'd1;
          end
        end
        OVER: begin
          if (p1_rise || p2_rise) begin
            score_p1  <= 4'd0;
            score_p2  <= 4'd0;
            game_over <= 1'b0;
            side      <= SIDE_P2;
            ball_rst  <= 1'b1;
            st        <= SERVE;
          end
        end
        default: st <= SERVE;
      endcase
    end
  end
endmodule
